hazard_bubble_ctrl: RTL
=======================

HAZARD_BUBBLE_CTRL -- requirements
Module: hazard_bubble_ctrl

Interface
REQ-001 SHALL have parameter BRANCH_PENALTY, default 1, meaning NOP cycles inserted after a BRANCH/JAL/JALR issues; legal range 0..7.
REQ-002 SHALL have parameter HIST_DEPTH, default 2, meaning the number of previously issued instructions tracked for register hazards; legal range 1..4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port icache_dout, input, 32, the fetched instruction.
REQ-006 SHALL have port stall, input, 1, external pipeline stall.
REQ-007 SHALL have port nop_sel, output, 1; 1 selects NOP, 0 selects icache_dout.
REQ-008 SHALL have port hold_pc, output, 1; 1 means fetch replays the same PC next cycle.
REQ-009 SHALL have port issued_inst, output, 32; 32'h0000_0013 when nop_sel=1, else icache_dout.

Function
REQ-010 SHALL implement FSM states RUN and FLUSH, plus a 3-bit flush counter cnt.
REQ-011 SHALL keep a history shift register of HIST_DEPTH entries {valid, rd[4:0], is_load}; entry 0 is the most recent issue.
REQ-012 An entry SHALL be valid only if its opcode writes rd (not BRANCH/STORE) and rd != 0.
REQ-013 Priority, highest first: rst, stall, FLUSH, JALR hazard, load-use hazard, normal issue.
REQ-014 When stall=1: nop_sel=1, hold_pc=1; FSM, cnt and history are frozen.
REQ-015 In FLUSH: nop_sel=1, hold_pc=0; cnt decrements each non-stalled cycle; FSM returns to RUN on the cycle cnt goes from 1 to 0.
REQ-016 JALR hazard: in RUN, if the opcode is JALR and rs1 matches rd of any valid history entry, then nop_sel=1 and hold_pc=1.
REQ-017 Normal issue in RUN: nop_sel=0, hold_pc=0, and the instruction's entry is shifted into history.
REQ-018 If a normal-issued opcode is BRANCH, JAL or JALR and BRANCH_PENALTY>0, the next state SHALL be FLUSH with cnt=BRANCH_PENALTY; if BRANCH_PENALTY=0, the FSM stays in RUN.
REQ-019 Every non-stalled cycle with nop_sel=1 SHALL shift an invalid entry into history, so a JALR hazard clears after at most HIST_DEPTH bubbles.
REQ-020 Outputs SHALL be combinational from registered state and current inputs; latency from hazard detection to bubble is 0 cycles.

Reset
REQ-021 While rst=1: nop_sel=1, hold_pc=1, issued_inst=32'h0000_0013.
REQ-022 rst SHALL set FSM=RUN, cnt=0 and all history entries invalid, including when asserted mid-FLUSH.
REQ-023 The first cycle after reset release SHALL issue normally when no hazard is present.

Configuration
REQ-024 Macro HAZARD_LOAD_USE_EN, when defined, SHALL enable load-use detection: in RUN, if entry 0 is a valid load and icache_dout uses rs1 or rs2 equal to its rd, then nop_sel=1 and hold_pc=1 for one cycle.
REQ-025 Without HAZARD_LOAD_USE_EN, is_load SHALL not be stored and no load-use bubble is generated.

Structure
REQ-026 Opcode constants SHALL come from the shared Opcode.vh header; NOP encoding and history-entry field widths SHALL go in a shared package/header.
REQ-027 One sub-module, hazard_hist, SHALL hold the history register and its match logic (rs1/rs2 in, hit flags out).

Verification
REQ-028 BRANCH_PENALTY=2: issue BEQ, then ADD on both following cycles -> nop_sel=0,1,1, then ADD issues on cycle 4.
REQ-029 HIST_DEPTH=2: issue ADDI x5, then JALR rs1=x5 -> two bubbles with hold_pc=1, then JALR issues.
REQ-030 Issue ADDI x0, then JALR rs1=x0 -> no bubble.
REQ-031 stall=1 for 3 cycles mid-FLUSH with cnt=1 -> nop_sel=1 throughout and cnt stays 1; flush completes one cycle after stall drops.
REQ-032 With HAZARD_LOAD_USE_EN: issue LW x7, then ADD x8,x7,x1 -> exactly one bubble; without the macro -> no bubble.
REQ-033 Assert rst mid-FLUSH -> nop_sel=1 immediately; after release, ADD issues on the first cycle.

Source files
------------

// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared constants and types for the hazard/bubble controller: RV32 opcodes, NOP encoding, history entry.
// No logic, no latency.
// Opcode classification helpers are pure functions used by the top and the history block.
package hazard_bubble_ctrl_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Register index width
    localparam int REG_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // One tracked issue slot: does it write a live register, which one, and was it a load
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } hist_entry_t;

    // Everything except branches and stores produces a destination register
    function automatic logic writes_rd(input logic [6:0] op);
        return (op != OPC_BRANCH) && (op != OPC_STORE);
    endfunction

    // rs1 is a real source for all formats except U-type and JAL
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
    endfunction

    // rs2 is a real source only for R-type, stores and branches
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
    endfunction

    // Instructions that redirect fetch and therefore need a flush window
    function automatic logic is_ctrl_xfer(input logic [6:0] op);
        return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/hazard_bubble_ctrl_hist.sv
// Issue history shift register (entry 0 = most recent) with source-register match logic.
// Match flags are combinational from stored history; new entry is visible the cycle after shift.
// No backpressure of its own: the controller decides when to shift (frozen while shift=0).
module hazard_hist
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int HIST_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  hist_entry_t      entry_in,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_hit,
    output logic             rs1_load_hit,
    output logic             rs2_load_hit
);

    hist_entry_t hist_q [HIST_DEPTH];

    // Shift register: newest issue enters at slot 0, oldest falls off the end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (shift) begin
            hist_q[0] <= entry_in;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // rs1 against every live entry (JALR target dependency)
    always_comb begin
        rs1_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_q[i].valid && (hist_q[i].rd == rs1)) begin
                rs1_hit = 1'b1;
            end
        end
    end

    // Load-use only matters against the immediately preceding issue
    always_comb begin
        rs1_load_hit = hist_q[0].valid && hist_q[0].is_load && (hist_q[0].rd == rs1);
        rs2_load_hit = hist_q[0].valid && hist_q[0].is_load && (hist_q[0].rd == rs2);
    end

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// Decode-stage bubble controller: picks NOP vs fetched instruction, holds PC on hazards/stall.
// Zero-cycle latency: outputs are combinational from registered state and current inputs.
// stall freezes all state; optional load-use detection enabled by defining HAZARD_LOAD_USE_EN.
module hazard_bubble_ctrl
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 1,
    parameter int HIST_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] icache_dout,
    input  logic        stall,
    output logic        nop_sel,
    output logic        hold_pc,
    output logic [31:0] issued_inst
);

    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;

    logic [6:0]       opcode;
    logic [REG_W-1:0] rd, rs1, rs2;

    hist_entry_t      issue_entry;
    hist_entry_t      hist_in;
    logic             hist_shift;
    logic             rs1_hit, rs1_load_hit, rs2_load_hit;
    logic             jalr_hazard, load_use_hazard;

    assign opcode = icache_dout[6:0];
    assign rd     = icache_dout[11:7];
    assign rs1    = icache_dout[19:15];
    assign rs2    = icache_dout[24:20];

    // History entry the current instruction would leave behind if it issues
    always_comb begin
        issue_entry.valid = writes_rd(opcode) && (rd != '0);
        issue_entry.rd    = rd;
`ifdef HAZARD_LOAD_USE_EN
        issue_entry.is_load = (opcode == OPC_LOAD);
`else
        // Load flag is never recorded, so the load-use match below can never fire
        issue_entry.is_load = 1'b0;
`endif
    end

    hazard_hist #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk          (clk),
        .rst          (rst),
        .shift        (hist_shift),
        .entry_in     (hist_in),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_hit      (rs1_hit),
        .rs1_load_hit (rs1_load_hit),
        .rs2_load_hit (rs2_load_hit)
    );

    // Hazard qualification against the fetched instruction's real sources
    always_comb begin
        jalr_hazard     = (opcode == OPC_JALR) && rs1_hit;
        load_use_hazard = (uses_rs1(opcode) && rs1_load_hit)
                       || (uses_rs2(opcode) && rs2_load_hit);
    end

    // FSM state and flush counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Priority: reset, stall, flush window, JALR hazard, load-use, normal issue
    always_comb begin
        nop_sel    = 1'b0;
        hold_pc    = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        hist_shift = 1'b0;
        hist_in    = '0;

        if (rst) begin
            nop_sel = 1'b1;
            hold_pc = 1'b1;
        end else if (stall) begin
            nop_sel = 1'b1;
            hold_pc = 1'b1;
        end else if (state == FLUSH) begin
            // Fetch keeps advancing; the wrong-path words are squashed here
            nop_sel    = 1'b1;
            hist_shift = 1'b1;
            if (cnt <= 3'd1) begin
                cnt_nxt   = 3'd0;
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - 3'd1;
            end
        end else if (jalr_hazard || load_use_hazard) begin
            // Bubble ages the history so a JALR dependency drains within HIST_DEPTH cycles
            nop_sel    = 1'b1;
            hold_pc    = 1'b1;
            hist_shift = 1'b1;
        end else begin
            hist_shift = 1'b1;
            hist_in    = issue_entry;
            if (is_ctrl_xfer(opcode) && (BRANCH_PENALTY > 0)) begin
                state_nxt = FLUSH;
                cnt_nxt   = 3'(BRANCH_PENALTY);
            end
        end
    end

    assign issued_inst = nop_sel ? NOP_INST : icache_dout;

endmodule
